// File: rtl/parity_seq_ctrl.sv
// parity_seq_ctrl: accumulates the XOR parity of a len-word packet and flags a mismatch against exp_par.
// Define PARITY_ERRCNT_EN to add the saturating err_cnt mismatch counter port.
module parity_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] len,
  input  logic       exp_par,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_data,
  output logic       busy,
  output logic       done,
  output logic       par_out,
  output logic       err
`ifdef PARITY_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_len, r_cnt;
  logic       r_exp, r_acc, r_par_out, r_err;
  logic       w_accept, w_last, w_acc_par;
  assign in_ready  = r_state == RUN;
  assign busy      = r_state != IDLE;
  assign done      = r_state == CHECK;
  assign par_out   = r_par_out;
  assign err       = r_err;
  // abort beats a simultaneous accept, so the word never reaches the accumulator
  assign w_accept  = in_ready & in_valid & ~abort;
  assign w_last    = w_accept & (r_cnt + 4'd1 == r_len);
  assign w_acc_par = r_acc ^ (^in_data);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (abort ? IDLE : (w_last ? CHECK : RUN)) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_exp     <= 1'b0;
      r_acc     <= 1'b0;
      r_par_out <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_len     <= len == 4'd0 ? 4'd1 : len;
        r_exp     <= exp_par;
        r_acc     <= 1'b0;
        r_cnt     <= '0;
        r_par_out <= 1'b0;
        r_err     <= 1'b0;
      end
      if (w_accept) begin
        r_acc <= w_acc_par;
        r_cnt <= r_cnt + 4'd1;
      end
      // results land with the CHECK state so done, par_out and err appear together
      if (w_last) begin
        r_par_out <= w_acc_par;
        r_err     <= w_acc_par != r_exp;
      end
    end
  end
`ifdef PARITY_ERRCNT_EN
  logic [7:0] r_err_cnt;
  assign err_cnt = r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else if (r_state == CHECK && r_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_parity_seq_ctrl.sv
// tb_parity_seq_ctrl: directed and randomized packets checked against a parity model built from counts of ones.
module tb_parity_seq_ctrl;
  logic       clk = 0, rst_n = 0, start = 0, exp_par = 0, abort = 0, in_valid = 0;
  logic [3:0] len = 0;
  logic [6:0] in_data = 0;
  logic       in_ready, busy, done, par_out, err;
`ifdef PARITY_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  int total = 0, bad = 0, m_errs = 0;
  logic [6:0] pat[$];
  parity_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .exp_par(exp_par), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
    .par_out(par_out), .err(err)
`ifdef PARITY_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // mode: 0 back-to-back, 1 alternating valid, 2 random valid; abort_at = valid-word index carrying abort (-1 none)
  task automatic send_packet(input int l, input bit ep, input int mode, input int abort_at, input bit stray);
    int  eff = (l == 0) ? 1 : l;
    int  n = 0, vcnt = 0, cyc = 0;
    bit  par = 0, ab;
    @(negedge clk);
    start = 1; len = 4'(l); exp_par = ep;
    @(negedge clk);
    start = 0;
    check("run_busy", busy, 1);
    check("start_clr_par", par_out, 0);
    check("start_clr_err", err, 0);
    while (n < eff) begin
      check("run_ready", in_ready, 1);
      check("no_early_done", done, 0);
      if (cyc > 100) begin
        check("accept_timeout", n, eff);
        return;
      end
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom % 3 != 0);
      in_data  = (in_valid && pat.size() != 0) ? pat.pop_front() : 7'($urandom);
      ab       = in_valid && vcnt == abort_at;
      abort    = ab;
      start    = stray && ($urandom % 2 == 1);
      len      = 4'($urandom);
      @(negedge clk);
      abort = 0; start = 0;
      if (ab) begin
        in_valid = 0;
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 0);
        check("abort_done", done, 0);
        check("abort_par", par_out, 0);
        check("abort_err", err, 0);
        return;
      end
      if (in_valid) begin
        vcnt++; n++;
        par ^= 1'($countones(in_data) % 2);
      end
      cyc++;
    end
    check("done", done, 1);
    check("par_out", par_out, par);
    check("err", err, par != ep);
    check("check_busy", busy, 1);
    check("check_ready", in_ready, 0);
    if (par != ep && m_errs < 255) m_errs++;
    in_valid = 1; in_data = 7'($urandom); start = 1; len = 4'($urandom);
    @(negedge clk);
    start = 0; in_valid = 0;
    check("done_pulse_end", done, 0);
    check("check_start_ignored", busy, 0);
    check("hold_par", par_out, par);
    check("hold_err", err, par != ep);
  endtask
  initial begin
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_par", par_out, 0);
    check("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    pat = {7'h01, 7'h03, 7'h07};
    send_packet(3, 1, 0, -1, 0);
    pat = {7'h7F};
    send_packet(0, 0, 0, -1, 0);
    pat = {7'h01, 7'h02, 7'h04, 7'h08};
    send_packet(4, 0, 1, -1, 0);
    send_packet(5, 0, 0, 1, 0);
    @(negedge clk);
    start = 1; len = 4; exp_par = 0;
    @(negedge clk);
    start = 0; in_valid = 1; in_data = 7'h01;
    @(negedge clk);
    in_data = 7'h03;
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_par", par_out, 0);
    check("mid_rst_err", err, 0);
    m_errs = 0;
    @(negedge clk);
    rst_n = 1;
    pat = {7'h01, 7'h03, 7'h05, 7'h0F};
    send_packet(4, 1, 0, -1, 0);
    repeat (40)
      send_packet(int'($urandom % 16), 1'($urandom % 2), int'($urandom % 3),
                  ($urandom % 4 == 0) ? int'($urandom % 3) : -1, 1'($urandom % 2));
    repeat (300) begin
      pat = {7'h01};
      send_packet(1, 0, 0, -1, 0);
    end
`ifdef PARITY_ERRCNT_EN
    check("err_cnt_sat", err_cnt, m_errs);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
